seq_serializer: RTL and testbench
=================================

# seq_serializer

Upstream feeder for the `1001` sequence detector. It accepts parallel words over a valid/ready handshake and buffers them in a small FIFO. It shifts each word out one bit per clock on `seqOut`, which drives the detector's serial input directly. Words are sent back-to-back with no gap bits; the line rests at a fixed idle level when no data is queued.

## Interface
- `DATA_W`, 8: word width in bits, ≥2.
- `FIFO_DEPTH`, 4: word buffer entries; power of two, ≥2.
- `MSB_FIRST`, 1: 1 = shift MSB first, 0 = LSB first.
- `IDLE_BIT`, 0: `seqOut` level when nothing is being shifted.

Ports:
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `clr`  in  1  synchronous flush, active-high.
- `wrData`  in  DATA_W  word to serialize.
- `wrValid`  in  1  `wrData` is valid.
- `wrReady`  out  1  FIFO can accept a word.
- `seqOut`  out  1  serial bit; connects to the detector's `seqIn`.
- `bitValid`  out  1  `seqOut` carries a data bit this cycle.
- `wordStart`  out  1  `seqOut` carries bit 0 of the shift order (first bit of a word).
- `busy`  out  1  FIFO non-empty or a word is shifting.

## Operation
- Reset values while `rst`=0: FIFO empty, state IDLE, `seqOut`=IDLE_BIT, `bitValid`=0, `wordStart`=0, `busy`=0, `wrReady`=1.
- FIFO write:
  - A write occurs on `wrValid && wrReady`.
  - `wrReady` = !full, computed from registered occupancy only.
  - A pop in the same cycle does not free a slot for a simultaneous write when full.
- Occupancy counter width is clog2(FIFO_DEPTH)+1. Read and write pointers wrap modulo FIFO_DEPTH.
- Shifter FSM, two states:
  - IDLE: if FIFO non-empty, pop the head into the shift register, set bitCnt = DATA_W-1, go to SHIFT. Otherwise hold.
  - SHIFT: each cycle, present the next bit and decrement bitCnt.
    - At bitCnt=0 with FIFO non-empty: pop and reload in the same cycle, stay in SHIFT. The next word follows with no gap.
    - At bitCnt=0 with FIFO empty: go to IDLE.
- Outputs are registered.
  - `seqOut` holds the current shift-register bit in SHIFT, and IDLE_BIT otherwise.
  - `bitValid`=1 exactly for the DATA_W cycles of each word.
  - `wordStart`=1 on the first of those cycles.
- `clr`:
  - Empties the FIFO and aborts any word in flight.
  - Forces IDLE and all outputs to their reset values on the next cycle.
  - Overrides a simultaneous write; the written word is discarded.
- Reset mid-word: the partial word is lost and `seqOut` returns to IDLE_BIT immediately (asynchronous). There is no resumption.

## Timing
- Word accepted at edge n into an empty FIFO with the FSM in IDLE:
  - pop at edge n+1;
  - first bit on `seqOut` after edge n+2, i.e. 2 cycles of latency;
  - last bit after edge n+1+DATA_W.
- Sustained throughput: one word per DATA_W cycles.
- Maximum storage: FIFO_DEPTH queued words plus one word in the shifter.

## Structure
- Shared package holds:
  - FSM state encoding (IDLE=0, SHIFT=1);
  - the IDLE_BIT default;
  - a clog2 helper constant function, reusable by the detector's testbench.
- One sub-module, `seq_ser_fifo`: a synchronous FIFO with push/pop, full/empty and count.
- The top level holds the FSM, the shift register and bitCnt.

## Test plan
- Single word: `wrData`=0x99, MSB_FIRST=1, written at cycle 0.
  - `seqOut` = 1,0,0,1,1,0,0,1 on cycles 2–9, `wordStart` on cycle 2, `bitValid` on 2–9.
  - With the detector attached downstream, `detOut` asserts twice.
- Back-to-back: 0xA5, 0x3C, 0xFF, 0x00 written on consecutive cycles.
  - 32 contiguous `bitValid` cycles with no gap.
  - `wordStart` on cycles 2, 10, 18, 26.
  - `busy` drops on cycle 34.
- Backpressure: `wrValid` held high for 8 cycles with incrementing data (DEPTH=4).
  - `wrReady` falls after 5 accepted words.
  - Exactly 5 words are serialized, in order.
- Flush: `clr` pulsed at bit 3 of word 0xF0 while 2 words are queued.
  - Next cycle: `seqOut`=IDLE_BIT, `bitValid`=0, `busy`=0, `wrReady`=1.
  - No further bits are emitted.
- Async reset: `rst` dropped mid-word, between clock edges.
  - Outputs take their reset values before the next edge.
  - After release, a new word 0x81 serializes correctly.
- LSB_FIRST (MSB_FIRST=0): word 0x01 gives `seqOut` = 1,0,0,0,0,0,0,0.

Source files
------------

// File: rtl/seq_serializer_pkg.sv
// Shared definitions for the 1001 serializer / detector slice: FSM encoding,
// default idle line level and a clog2 helper usable from benches as well.
package seq_serializer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } serState_t;

  localparam logic IDLE_BIT_DFLT = 1'b0;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/seq_ser_fifo.sv
// Word buffer for the serializer: synchronous FIFO, combinational head read.
// Latency 1 cycle write-to-visible; full is registered-occupancy only, so a pop never admits a same-cycle push.
module seq_ser_fifo
  import seq_serializer_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  localparam int AW    = clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              push,
  input  logic [DATA_W-1:0] pushData,
  input  logic              pop,
  output logic [DATA_W-1:0] popData,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wrPtr;
  logic [AW-1:0]     rdPtr;
  logic              doPush;
  logic              doPop;

  // A flush wins over both ports so nothing written alongside it survives.
  assign doPush  = push && !full && !clr;
  assign doPop   = pop && !empty && !clr;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign popData = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (clr) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (doPop)  rdPtr <= rdPtr + AW'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/seq_serializer.sv
// Parallel-to-serial feeder for the 1001 detector: FIFO-buffered words shifted out back-to-back.
// First bit 2 cycles after acceptance; wrReady drops only when the FIFO is full.
module seq_serializer
  import seq_serializer_pkg::*;
#(
  parameter int   DATA_W     = 8,
  parameter int   FIFO_DEPTH = 4,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_BIT   = IDLE_BIT_DFLT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic [DATA_W-1:0] wrData,
  input  logic              wrValid,
  output logic              wrReady,
  output logic              seqOut,
  output logic              bitValid,
  output logic              wordStart,
  output logic              busy
);

  localparam int BW = clog2(DATA_W);
  localparam int FW = clog2(FIFO_DEPTH) + 1;

  serState_t         state;
  logic [DATA_W-1:0] shReg;
  logic [BW-1:0]     bitCnt;
  logic [DATA_W-1:0] fifoData;
  logic [FW-1:0]     fifoCount;
  logic              fifoFull;
  logic              fifoEmpty;
  logic              fifoPop;
  logic              curBit;
  logic              lastBit;

  assign wrReady = !fifoFull;
  assign curBit  = MSB_FIRST ? shReg[DATA_W-1] : shReg[0];
  assign lastBit = (bitCnt == '0);
  // Reload happens either from idle or on the last bit, which keeps words gap-free.
  assign fifoPop = !fifoEmpty && ((state == ST_IDLE) || lastBit);

  seq_ser_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .push     (wrValid),
    .pushData (wrData),
    .pop      (fifoPop),
    .popData  (fifoData),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (fifoCount)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      shReg     <= '0;
      bitCnt    <= '0;
      seqOut    <= IDLE_BIT;
      bitValid  <= 1'b0;
      wordStart <= 1'b0;
      busy      <= 1'b0;
    end else if (clr) begin
      state     <= ST_IDLE;
      shReg     <= '0;
      bitCnt    <= '0;
      seqOut    <= IDLE_BIT;
      bitValid  <= 1'b0;
      wordStart <= 1'b0;
      busy      <= 1'b0;
    end else begin
      busy <= (fifoCount != '0) || (state == ST_SHIFT);
      case (state)
        ST_IDLE: begin
          seqOut    <= IDLE_BIT;
          bitValid  <= 1'b0;
          wordStart <= 1'b0;
          if (!fifoEmpty) begin
            shReg  <= fifoData;
            bitCnt <= BW'(DATA_W - 1);
            state  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          seqOut    <= curBit;
          bitValid  <= 1'b1;
          wordStart <= (bitCnt == BW'(DATA_W - 1));
          if (lastBit) begin
            if (!fifoEmpty) begin
              shReg  <= fifoData;
              bitCnt <= BW'(DATA_W - 1);
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            shReg  <= MSB_FIRST ? {shReg[DATA_W-2:0], 1'b0} : {1'b0, shReg[DATA_W-1:1]};
            bitCnt <= bitCnt - BW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_serializer.sv
// Bench for seq_serializer: MSB-first and LSB-first instances share stimulus and
// are checked every cycle against a word-queue model, plus directed literal checks.
module tb_seq_serializer;
  import seq_serializer_pkg::*;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         clr = 1'b0;
  logic         wrValid = 1'b0;
  logic [W-1:0] wrData = '0;

  logic wrReadyM, seqOutM, bitValidM, wordStartM, busyM;
  logic wrReadyL, seqOutL, bitValidL, wordStartL, busyL;

  int checks = 0;
  int errors = 0;
  int edgeN  = 0;

  seq_serializer #(.DATA_W(W), .FIFO_DEPTH(D), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dutM (
    .clk(clk), .rst(rst), .clr(clr), .wrData(wrData), .wrValid(wrValid),
    .wrReady(wrReadyM), .seqOut(seqOutM), .bitValid(bitValidM),
    .wordStart(wordStartM), .busy(busyM)
  );

  seq_serializer #(.DATA_W(W), .FIFO_DEPTH(D), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dutL (
    .clk(clk), .rst(rst), .clr(clr), .wrData(wrData), .wrValid(wrValid),
    .wrReady(wrReadyL), .seqOut(seqOutL), .bitValid(bitValidL),
    .wordStart(wordStartL), .busy(busyL)
  );

  always #5 clk = ~clk;

  // Model: FIFO as a queue of words, shifter as (word, next bit index, active).
  logic [W-1:0] fq[$];
  logic [W-1:0] curWord;
  int           curIdx;
  bit           curAct;
  logic         eSeqM, eSeqL, eValid, eStart, eBusy;

  task automatic modelReset();
    fq.delete();
    curAct = 0;
    curIdx = 0;
    eSeqM = 1'b0; eSeqL = 1'b0; eValid = 1'b0; eStart = 1'b0; eBusy = 1'b0;
  endtask

  task automatic modelStep();
    bit accept;
    if (!rst || clr) begin
      modelReset();
      return;
    end
    eBusy  = (fq.size() != 0) || curAct;
    accept = wrValid && (fq.size() < D);
    if (curAct) begin
      eValid = 1'b1;
      eStart = (curIdx == 0);
      eSeqM  = curWord[W-1-curIdx];
      eSeqL  = curWord[curIdx];
      curIdx++;
      if (curIdx == W) curAct = 0;
    end else begin
      eValid = 1'b0; eStart = 1'b0; eSeqM = 1'b0; eSeqL = 1'b0;
    end
    if (!curAct && fq.size() != 0) begin
      curWord = fq.pop_front();
      curIdx  = 0;
      curAct  = 1;
    end
    if (accept) fq.push_back(wrData);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", name, edgeN, act, exp);
    end
  endtask

  task automatic compareAll();
    logic eReady;
    eReady = (fq.size() < D);
    chk("seqOutM", seqOutM, eSeqM);
    chk("seqOutL", seqOutL, eSeqL);
    chk("bitValidM", bitValidM, eValid);
    chk("bitValidL", bitValidL, eValid);
    chk("wordStartM", wordStartM, eStart);
    chk("wordStartL", wordStartL, eStart);
    chk("busyM", busyM, eBusy);
    chk("busyL", busyL, eBusy);
    chk("wrReadyM", wrReadyM, eReady);
    chk("wrReadyL", wrReadyL, eReady);
  endtask

  task automatic step();
    @(posedge clk);
    modelStep();
    edgeN++;
    @(negedge clk);
    compareAll();
  endtask

  task automatic idle(input int n);
    wrValid = 1'b0;
    clr     = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int t0, rel, dets, vcnt, accepted, busyDrop;
    logic [W-1:0] bitsM, bitsL;
    logic [3:0] win;
    int starts[$];
    logic bitq[$];

    modelReset();
    // Reset state
    step();
    step();
    chk("reset_seqOut", seqOutM, 0);
    chk("reset_wrReady", wrReadyM, 1);
    rst = 1'b1;
    idle(2);

    // Single word 0x99, MSB first, detector downstream must fire twice
    wrData = 8'h99; wrValid = 1'b1;
    step();
    t0 = edgeN; wrValid = 1'b0;
    bitsM = '0; vcnt = 0; starts.delete();
    for (int i = 0; i < 12; i++) begin
      step();
      rel = edgeN - t0;
      if (bitValidM) vcnt++;
      if (wordStartM) starts.push_back(rel);
      if (rel >= 2 && rel <= 9) bitsM = {bitsM[W-2:0], seqOutM};
    end
    chk("single_bits", bitsM, 8'h99);
    chk("single_valid_cycles", vcnt, 8);
    chk("single_start_cycle", (starts.size() == 1) ? starts[0] : -1, 2);
    dets = 0; win = '0;
    for (int i = W - 1; i >= 0; i--) begin
      win = {win[2:0], bitsM[i]};
      if (win == 4'b1001) dets++;
    end
    chk("single_detections", dets, 2);

    // Back-to-back words
    starts.delete(); vcnt = 0; busyDrop = -1;
    wrValid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: wrData = 8'hA5;
        1: wrData = 8'h3C;
        2: wrData = 8'hFF;
        default: wrData = 8'h00;
      endcase
      step();
      if (i == 0) t0 = edgeN;
      if (wordStartM) starts.push_back(edgeN - t0);
      if (bitValidM) vcnt++;
    end
    wrValid = 1'b0;
    for (int i = 0; i < 36; i++) begin
      step();
      rel = edgeN - t0;
      if (wordStartM) starts.push_back(rel);
      if (bitValidM) vcnt++;
      if (!busyM && busyDrop < 0) busyDrop = rel;
    end
    chk("b2b_valid_cycles", vcnt, 32);
    chk("b2b_start_count", starts.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("b2b_start_cycle", (i < starts.size()) ? starts[i] : -1, 2 + 8 * i);
    chk("b2b_busy_drop", busyDrop, 34);

    // Backpressure: 8 cycles of wrValid with incrementing data
    accepted = 0; bitq.delete();
    wrValid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wrData = W'(8'h10 + i);
      if (wrReadyM) accepted++;
      step();
      if (bitValidM) bitq.push_back(seqOutM);
    end
    chk("bp_ready_low_after5", wrReadyM, 0);
    wrValid = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (bitValidM) bitq.push_back(seqOutM);
    end
    chk("bp_accepted", accepted, 5);
    chk("bp_bits", bitq.size(), 40);
    for (int w = 0; w < 5; w++) begin
      bitsM = '0;
      for (int b = 0; b < W; b++)
        if (w * W + b < bitq.size()) bitsM = {bitsM[W-2:0], bitq[w*W+b]};
      chk("bp_word", bitsM, 8'h10 + w);
    end

    // Flush at bit 3 of 0xF0 with two words queued; a write alongside clr is dropped
    wrValid = 1'b1;
    wrData = 8'hF0; step(); t0 = edgeN;
    wrData = 8'h11; step();
    wrData = 8'h22; step();
    wrValid = 1'b0;
    step(); step();
    wrValid = 1'b1; wrData = 8'h77; clr = 1'b1;
    step();
    clr = 1'b0; wrValid = 1'b0;
    chk("flush_seqOut", seqOutM, 0);
    chk("flush_bitValid", bitValidM, 0);
    chk("flush_busy", busyM, 0);
    chk("flush_wrReady", wrReadyM, 1);
    vcnt = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (bitValidM || bitValidL) vcnt++;
    end
    chk("flush_no_bits", vcnt, 0);

    // Asynchronous reset mid-word
    wrValid = 1'b1; wrData = 8'hFF; step();
    wrValid = 1'b0;
    step(); step(); step(); step();
    @(posedge clk);
    modelStep();
    edgeN++;
    #3 rst = 1'b0;
    #1;
    chk("arst_seqOut", seqOutM, 0);
    chk("arst_bitValid", bitValidM, 0);
    chk("arst_busy", busyM, 0);
    chk("arst_wrReady", wrReadyM, 1);
    modelReset();
    @(negedge clk);
    compareAll();
    rst = 1'b1;
    idle(2);
    wrValid = 1'b1; wrData = 8'h81; step(); t0 = edgeN;
    wrValid = 1'b0; bitsM = '0;
    for (int i = 0; i < 12; i++) begin
      step();
      rel = edgeN - t0;
      if (rel >= 2 && rel <= 9) bitsM = {bitsM[W-2:0], seqOutM};
    end
    chk("arst_recover_bits", bitsM, 8'h81);

    // LSB-first instance: 0x01 leaves as 1 then seven 0s
    wrValid = 1'b1; wrData = 8'h01; step(); t0 = edgeN;
    wrValid = 1'b0; bitsL = '0;
    for (int i = 0; i < 12; i++) begin
      step();
      rel = edgeN - t0;
      if (rel >= 2 && rel <= 9) bitsL = {bitsL[W-2:0], seqOutL};
    end
    chk("lsb_bits_in_order", bitsL, 8'h80);

    // Randomized traffic with occasional flushes
    for (int i = 0; i < 600; i++) begin
      wrValid = ($urandom_range(0, 9) < 4);
      wrData  = W'($urandom);
      clr     = ($urandom_range(0, 79) == 0);
      step();
    end
    idle(60);
    chk("final_idle_busy", busyM, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
